// File: rtl/rv_pkg.sv
// Shared types and defaults for the ready/valid byte-stream blocks.
package rv_pkg;

  typedef logic [7:0] byte_t;

  localparam int RV_PACK_LANES_DEFAULT = 4;

endpackage

// File: rtl/rv_byte_packer.sv
// Packs a byte stream into little-endian LANES-byte words; in_last flushes a
// partial word with a contiguous keep mask. One byte per cycle when unstalled.
module rv_byte_packer
  import rv_pkg::*;
#(
  parameter int LANES = RV_PACK_LANES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last
);

  localparam int CW = $clog2(LANES);

  logic [CW-1:0]      cnt_reg;
  byte_t              asm_reg [LANES-1];
  logic [8*LANES-1:0] data_reg;
  logic [LANES-1:0]   keep_reg;
  logic               last_reg;
  logic               valid_reg;

  logic               wren;
  logic               at_top;
  logic               complete;
  logic [8*LANES-1:0] word_next;
  logic [LANES-1:0]   keep_next;

  // Ready depends only on the output register, never on the ingress byte.
  assign in_ready = ~valid_reg | out_ready;
  assign wren     = in_valid & in_ready;
  assign at_top   = (cnt_reg == CW'(LANES - 1));
  assign complete = wren & (in_last | at_top);

  // Lanes below cnt come from the assembly register, lane cnt from the
  // incoming byte, lanes above are zero-filled.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi < LANES - 1) begin : g_asm
      assign word_next[gi*8 +: 8] = (cnt_reg == CW'(gi)) ? in_data :
                                    (cnt_reg >  CW'(gi)) ? asm_reg[gi] : 8'h00;
    end else begin : g_top
      assign word_next[gi*8 +: 8] = (cnt_reg == CW'(gi)) ? in_data : 8'h00;
    end
    assign keep_next[gi] = (cnt_reg >= CW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      for (int i = 0; i < LANES - 1; i++) asm_reg[i] <= '0;
    end else if (complete) begin
      cnt_reg <= '0;
    end else if (wren) begin
      for (int i = 0; i < LANES - 1; i++)
        if (cnt_reg == CW'(i)) asm_reg[i] <= in_data;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A completing byte reloads the output even while the old word drains,
  // so back-to-back words leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (complete) begin
      data_reg  <= word_next;
      keep_reg  <= keep_next;
      last_reg  <= in_last;
      valid_reg <= 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_keep  = keep_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_rv_byte_packer.sv
// Scoreboard bench for rv_byte_packer: directed frames, backpressure,
// mid-word reset and a long randomised-handshake run.
module tb_rv_byte_packer;
  import rv_pkg::*;

  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = 8'h00;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_keep;
  logic               out_last;

  typedef struct packed {
    logic [8*LANES-1:0] data;
    logic [LANES-1:0]   keep;
    logic               last;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    stalls = 0;
  int    words_seen = 0;
  int    rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  rv_byte_packer #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected word for every egress handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      word_t e;
      tests++;
      words_seen++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got data=%h keep=%h last=%0d, required none",
                 out_data, out_keep, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_keep !== e.keep || out_last !== e.last) begin
          fails++;
          $display("FAIL word%0d: got data=%h keep=%h last=%0d, required data=%h keep=%h last=%0d",
                   words_seen, out_data, out_keep, out_last, e.data, e.keep, e.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input byte_t b, input logic l);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      stalls++;
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", waitc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Reference packing of a frame into little-endian words for the random run.
  task automatic push_frame(input byte_t fr[$]);
    word_t w;
    int    lane = 0;
    w = '0;
    foreach (fr[i]) begin
      w.data[lane*8 +: 8] = fr[i];
      w.keep[lane] = 1'b1;
      lane++;
      if (lane == LANES || i == fr.size() - 1) begin
        w.last = (i == fr.size() - 1);
        exp_q.push_back(w);
        w = '0;
        lane = 0;
      end
    end
  endtask

  initial begin
    byte_t fr[$];

    idle(3);
    rst = 1'b0;
    #0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_keep", 64'(out_keep), 64'd0);
    check("reset_out_last", 64'(out_last), 64'd0);

    // Two full words, frame ends on the second.
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h08070605, 4'hF, 1'b1);
    stalls = 0;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    check("full_rate_stalls", 64'(stalls), 64'd0);
    drain("two_words");

    // Three-byte flush with one-cycle latency.
    push(32'h00CCBBAA, 4'h7, 1'b1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    check("partial_not_early", 64'(out_valid), 64'd0);
    send(8'hCC, 1'b1);
    check("flush_latency", 64'(out_valid), 64'd1);
    drain("three_byte");

    // Single-byte frame.
    push(32'h0000005A, 4'h1, 1'b1);
    send(8'h5A, 1'b1);
    drain("single_byte");

    // Backpressure: first word held, in_ready low, outputs stable.
    rdy_mode = 0;
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h08070605, 4'hF, 1'b1);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h05;
    in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_data", 64'(out_data), 64'h04030201);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
    drain("backpressure");

    // Reset in the middle of a word discards it.
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midword_rst_valid", 64'(out_valid), 64'd0);
    push(32'h14131211, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i), i == 3);
    drain("after_reset");

    // Random handshakes over many frames.
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      int len = $urandom_range(1, 17);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      push_frame(fr);
      for (int i = 0; i < len; i++) begin
        int gap = $urandom_range(0, 2);
        if (gap == 2) idle(1);
        send(fr[i], i == len - 1);
      end
    end
    rdy_mode = 1;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
